// File: rtl/sg_monitor_pkg.sv
// Shared types and helpers for the state-graph conformance monitor.
// tr_entry places one field at its slot when building the packed transition tables.
package sg_monitor_pkg;

    typedef enum logic [2:0] {V_NONE, V_ENA, V_MULTI, V_IN, V_OUT} viol_kind_e;

    localparam logic DIR_FALL = 1'b0;
    localparam logic DIR_RISE = 1'b1;

    // Widest packed table the helper can build; callers truncate to their own width.
    localparam int TBL_MAX_W = 1024;

    function automatic logic [TBL_MAX_W-1:0] tr_entry(input int idx, input int w, input int val);
        logic [TBL_MAX_W-1:0] v;
        logic [TBL_MAX_W-1:0] mask;
        mask = (TBL_MAX_W'(1) << w) - TBL_MAX_W'(1);
        v    = TBL_MAX_W'(val) & mask;
        return v << (idx * w);
    endfunction

endpackage

// File: rtl/sg_monitor_if.sv
// Signal bundle between the observed circuit side and the monitor.
// master drives the sampled signals; slave (the monitor) returns diagnostics.
interface sg_monitor_if #(
    parameter int NSIG  = 4,
    parameter int ENA_W = 4,
    parameter int CNT_W = 8,
    parameter int SW    = 4,
    parameter int XW    = 2
);
    logic [ENA_W-1:0] ena;
    logic [NSIG-1:0]  sig;
    logic             clear;

    logic [SW-1:0]    state;
    logic             viol;
    logic             err_in;
    logic             err_out;
    logic             err_multi;
    logic             err_ena;
    logic [CNT_W-1:0] viol_cnt;
    logic [SW-1:0]    first_state;
    logic [XW-1:0]    first_sig;
    logic             first_dir;
    logic             halted;

    modport master (
        output ena, sig, clear,
        input  state, viol, err_in, err_out, err_multi, err_ena,
               viol_cnt, first_state, first_sig, first_dir, halted
    );

    modport slave (
        input  ena, sig, clear,
        output state, viol, err_in, err_out, err_multi, err_ena,
               viol_cnt, first_state, first_sig, first_dir, halted
    );
endinterface

// File: rtl/sg_tr_lookup.sv
// Combinational search of the transition table for (state, signal, direction).
// Scanning from the top entry down lets the lowest matching entry win.
module sg_tr_lookup #(
    parameter int                   NTRANS  = 32,
    parameter int                   SW      = 4,
    parameter int                   XW      = 2,
    parameter logic [NTRANS*SW-1:0] TR_FROM = '0,
    parameter logic [NTRANS*XW-1:0] TR_SIG  = '0,
    parameter logic [NTRANS-1:0]    TR_DIR  = '0,
    parameter logic [NTRANS*SW-1:0] TR_TO   = '0
) (
    input  logic [SW-1:0] state,
    input  logic [XW-1:0] idx,
    input  logic          dir,
    output logic          hit,
    output logic [SW-1:0] to
);

    always_comb begin
        hit = 1'b0;
        to  = '0;
        for (int t = NTRANS - 1; t >= 0; t--) begin
            if (TR_FROM[t*SW +: SW] == state &&
                TR_SIG[t*XW +: XW] == idx &&
                TR_DIR[t] == dir) begin
                hit = 1'b1;
                to  = TR_TO[t*SW +: SW];
            end
        end
    end

endmodule

// File: rtl/sg_monitor.sv
// State-graph conformance monitor: tracks signal edges against a parameter-table
// graph, classifies illegal edges and keeps sticky diagnostics of the first one.
module sg_monitor
    import sg_monitor_pkg::*;
#(
    parameter int                   NSIG        = 4,
    parameter int                   NSTATE      = 16,
    parameter int                   NTRANS      = 32,
    parameter int                   ENA_W       = 4,
    parameter int                   CNT_W       = 8,
    parameter int                   SW          = (NSTATE > 1) ? $clog2(NSTATE) : 1,
    parameter int                   XW          = (NSIG > 1) ? $clog2(NSIG) : 1,
    parameter int                   INIT_STATE  = 0,
    parameter logic [NSIG-1:0]      INIT_SIG    = '0,
    parameter logic [NSIG-1:0]      INPUT_MASK  = '0,
    parameter logic [NTRANS*SW-1:0] TR_FROM     = '0,
    parameter logic [NTRANS*XW-1:0] TR_SIG      = '0,
    parameter logic [NTRANS-1:0]    TR_DIR      = '0,
    parameter logic [NTRANS*SW-1:0] TR_TO       = '0,
    parameter int                   HALT_ON_ERR = 1
) (
    input  logic        clk,
    input  logic        reset,
    sg_monitor_if.slave mon
);

    logic [NSIG-1:0]  sig_q;
    logic [SW-1:0]    state_q, state_d;
    logic [NSIG-1:0]  edges;
    logic [XW-1:0]    edge_idx;
    logic             edge_dir;
    logic             hit;
    logic [SW-1:0]    hit_to;
    viol_kind_e       kind;
    logic             viol_now;

    logic             viol_q, halted_q, have_first;
    logic             err_in_q, err_out_q, err_multi_q, err_ena_q;
    logic [CNT_W-1:0] cnt_q;
    logic [SW-1:0]    first_state_q;
    logic [XW-1:0]    first_sig_q;
    logic             first_dir_q;

    assign edges = mon.sig ^ sig_q;

    always_comb begin
        edge_idx = '0;
        for (int i = NSIG - 1; i >= 0; i--) begin
            if (edges[i]) edge_idx = XW'(i);
        end
    end

    assign edge_dir = mon.sig[edge_idx] ? DIR_RISE : DIR_FALL;

    sg_tr_lookup #(
        .NTRANS (NTRANS),
        .SW     (SW),
        .XW     (XW),
        .TR_FROM(TR_FROM),
        .TR_SIG (TR_SIG),
        .TR_DIR (TR_DIR),
        .TR_TO  (TR_TO)
    ) u_lookup (
        .state(state_q),
        .idx  (edge_idx),
        .dir  (edge_dir),
        .hit  (hit),
        .to   (hit_to)
    );

    // Classification in priority order: ena shape, then edge count, then table.
    always_comb begin
        kind = V_NONE;
        if (!$onehot0(mon.ena)) begin
            kind = V_ENA;
        end else if ($countones(edges) > 1) begin
            kind = V_MULTI;
        end else if (edges != '0 && !hit) begin
            kind = INPUT_MASK[edge_idx] ? V_IN : V_OUT;
        end
    end

    assign viol_now = (kind != V_NONE) && !halted_q;

    always_comb begin
        state_d = state_q;
        if (!halted_q && kind == V_NONE && edges != '0) state_d = hit_to;
    end

    // sig_q follows sig unconditionally so a bad edge is reported only once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sig_q   <= INIT_SIG;
            state_q <= SW'(INIT_STATE);
        end else begin
            sig_q   <= mon.sig;
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            viol_q        <= 1'b0;
            halted_q      <= 1'b0;
            have_first    <= 1'b0;
            err_in_q      <= 1'b0;
            err_out_q     <= 1'b0;
            err_multi_q   <= 1'b0;
            err_ena_q     <= 1'b0;
            cnt_q         <= '0;
            first_state_q <= '0;
            first_sig_q   <= '0;
            first_dir_q   <= 1'b0;
        end else begin
            viol_q <= viol_now;
            if (mon.clear) begin
                halted_q      <= 1'b0;
                have_first    <= 1'b0;
                err_in_q      <= 1'b0;
                err_out_q     <= 1'b0;
                err_multi_q   <= 1'b0;
                err_ena_q     <= 1'b0;
                cnt_q         <= '0;
                first_state_q <= '0;
                first_sig_q   <= '0;
                first_dir_q   <= 1'b0;
            end
            // A violation in the clear cycle overrides the clear for its own fields.
            if (viol_now) begin
                case (kind)
                    V_ENA:   err_ena_q   <= 1'b1;
                    V_MULTI: err_multi_q <= 1'b1;
                    V_IN:    err_in_q    <= 1'b1;
                    V_OUT:   err_out_q   <= 1'b1;
                    default: ;
                endcase
                if (mon.clear)   cnt_q <= CNT_W'(1);
                else if (!(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
                if (!have_first || mon.clear) begin
                    have_first    <= 1'b1;
                    first_state_q <= state_q;
                    first_sig_q   <= edge_idx;
                    first_dir_q   <= edge_dir;
                end
                if (HALT_ON_ERR != 0) halted_q <= 1'b1;
            end
        end
    end

    assign mon.state       = state_q;
    assign mon.viol        = viol_q;
    assign mon.err_in      = err_in_q;
    assign mon.err_out     = err_out_q;
    assign mon.err_multi   = err_multi_q;
    assign mon.err_ena     = err_ena_q;
    assign mon.viol_cnt    = cnt_q;
    assign mon.first_state = first_state_q;
    assign mon.first_sig   = first_sig_q;
    assign mon.first_dir   = first_dir_q;
    assign mon.halted      = halted_q;

endmodule

// File: tb/tb_sg_monitor.sv
// Bench for sg_monitor: 2-signal handshake graph on a halting and a non-halting
// instance, directed steps then random traffic, both checked against a table model.
module tb_sg_monitor;
    import sg_monitor_pkg::*;

    localparam int NSIG = 2, NSTATE = 4, NT = 8, ENA_W = 4, CNT_W = 8, SW = 2, XW = 1;
    localparam int FW_S = NT * SW;
    localparam int FW_X = NT * XW;
    localparam logic [NSIG-1:0] IN_MASK = 2'b01;

    // Handshake a(0, input) / b(1, output); entry 4+ duplicate entry 0 with other targets.
    localparam int T_FROM [NT] = '{0, 1, 2, 3, 0, 0, 0, 0};
    localparam int T_SIG  [NT] = '{0, 1, 0, 1, 0, 0, 0, 0};
    localparam int T_DIR  [NT] = '{1, 1, 0, 0, 1, 1, 1, 1};
    localparam int T_TO   [NT] = '{1, 2, 3, 0, 2, 3, 3, 3};

    localparam logic [FW_S-1:0] P_FROM = FW_S'(tr_entry(1, SW, 1) | tr_entry(2, SW, 2) | tr_entry(3, SW, 3));
    localparam logic [FW_X-1:0] P_SIG  = FW_X'(tr_entry(1, XW, 1) | tr_entry(3, XW, 1));
    localparam logic [NT-1:0]   P_DIR  = NT'(tr_entry(0, 1, int'(DIR_RISE)) | tr_entry(1, 1, 1) |
                                             tr_entry(4, 1, 1) | tr_entry(5, 1, 1) |
                                             tr_entry(6, 1, 1) | tr_entry(7, 1, 1));
    localparam logic [FW_S-1:0] P_TO   = FW_S'(tr_entry(0, SW, 1) | tr_entry(1, SW, 2) | tr_entry(2, SW, 3) |
                                               tr_entry(4, SW, 2) | tr_entry(5, SW, 3) |
                                               tr_entry(6, SW, 3) | tr_entry(7, SW, 3));

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NSIG-1:0]  sig_d = '0;
    logic [ENA_W-1:0] ena_d = '0;
    logic             clr_d = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sg_monitor_if #(.NSIG(NSIG), .ENA_W(ENA_W), .CNT_W(CNT_W), .SW(SW), .XW(XW)) bus_h ();
    sg_monitor_if #(.NSIG(NSIG), .ENA_W(ENA_W), .CNT_W(CNT_W), .SW(SW), .XW(XW)) bus_c ();

    assign bus_h.sig = sig_d;
    assign bus_h.ena = ena_d;
    assign bus_h.clear = clr_d;
    assign bus_c.sig = sig_d;
    assign bus_c.ena = ena_d;
    assign bus_c.clear = clr_d;

    sg_monitor #(
        .NSIG(NSIG), .NSTATE(NSTATE), .NTRANS(NT), .ENA_W(ENA_W), .CNT_W(CNT_W),
        .SW(SW), .XW(XW), .INIT_STATE(0), .INIT_SIG(2'b00), .INPUT_MASK(IN_MASK),
        .TR_FROM(P_FROM), .TR_SIG(P_SIG), .TR_DIR(P_DIR), .TR_TO(P_TO), .HALT_ON_ERR(1)
    ) dut_h (.clk(clk), .reset(rst_n), .mon(bus_h));

    sg_monitor #(
        .NSIG(NSIG), .NSTATE(NSTATE), .NTRANS(NT), .ENA_W(ENA_W), .CNT_W(CNT_W),
        .SW(SW), .XW(XW), .INIT_STATE(0), .INIT_SIG(2'b00), .INPUT_MASK(IN_MASK),
        .TR_FROM(P_FROM), .TR_SIG(P_SIG), .TR_DIR(P_DIR), .TR_TO(P_TO), .HALT_ON_ERR(0)
    ) dut_c (.clk(clk), .reset(rst_n), .mon(bus_c));

    // Reference model: index 0 = halting instance, 1 = free-running instance.
    int             m_state [2];
    logic [NSIG-1:0] m_sigq [2];
    bit             m_viol [2], m_in [2], m_out [2], m_multi [2], m_ena [2], m_halt [2], m_have [2];
    int             m_cnt [2], m_fs [2];
    bit             m_fx [2], m_fd [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_state[k] = 0; m_sigq[k] = '0; m_viol[k] = 0; m_in[k] = 0; m_out[k] = 0;
            m_multi[k] = 0; m_ena[k] = 0; m_halt[k] = 0; m_have[k] = 0; m_cnt[k] = 0;
            m_fs[k] = 0; m_fx[k] = 0; m_fd[k] = 0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int  ne, lo, ones, kind, nxt;
            bit  hit, was_halted, nv;
            ne = 0; lo = -1; ones = 0; kind = 0; hit = 0; nxt = m_state[k];
            was_halted = m_halt[k];
            for (int i = 0; i < NSIG; i++)
                if (sig_d[i] !== m_sigq[k][i]) begin ne++; if (lo < 0) lo = i; end
            for (int i = 0; i < ENA_W; i++) if (ena_d[i]) ones++;
            if (ones > 1) kind = 1;
            else if (ne > 1) kind = 2;
            else if (ne == 1) begin
                for (int t = 0; t < NT && !hit; t++)
                    if (T_FROM[t] == m_state[k] && T_SIG[t] == lo && T_DIR[t] == int'(sig_d[lo])) begin
                        hit = 1; nxt = T_TO[t];
                    end
                if (!hit) kind = IN_MASK[lo] ? 3 : 4;
            end
            if (lo < 0) lo = 0;
            nv = (kind != 0) && !was_halted;
            if (clr_d) begin
                m_in[k] = 0; m_out[k] = 0; m_multi[k] = 0; m_ena[k] = 0; m_halt[k] = 0;
                m_have[k] = 0; m_cnt[k] = 0; m_fs[k] = 0; m_fx[k] = 0; m_fd[k] = 0;
            end
            if (nv) begin
                case (kind)
                    1: m_ena[k] = 1;
                    2: m_multi[k] = 1;
                    3: m_in[k] = 1;
                    default: m_out[k] = 1;
                endcase
                if (m_cnt[k] < 255) m_cnt[k]++;
                if (!m_have[k]) begin
                    m_have[k] = 1; m_fs[k] = m_state[k]; m_fx[k] = lo[0]; m_fd[k] = sig_d[lo];
                end
                if (k == 0) m_halt[k] = 1;
            end else if (!was_halted && kind == 0 && ne == 1) begin
                m_state[k] = nxt;
            end
            m_viol[k] = nv;
            m_sigq[k] = sig_d;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic check_inst(input string tag, input int k, input logic [SW-1:0] st,
                              input logic [5:0] fl, input logic [CNT_W-1:0] cnt, input logic [3:0] fi);
        chk({tag, ":state"}, 32'(st), 32'(m_state[k]));
        chk({tag, ":flags"}, 32'(fl), {26'd0, m_viol[k], m_in[k], m_out[k], m_multi[k], m_ena[k], m_halt[k]});
        chk({tag, ":cnt"}, 32'(cnt), 32'(m_cnt[k]));
        chk({tag, ":first"}, 32'(fi), {28'd0, 2'(m_fs[k]), m_fx[k], m_fd[k]});
    endtask

    task automatic check_all(input string tag);
        check_inst({tag, "/halt"}, 0, bus_h.state,
                   {bus_h.viol, bus_h.err_in, bus_h.err_out, bus_h.err_multi, bus_h.err_ena, bus_h.halted},
                   bus_h.viol_cnt, {bus_h.first_state, bus_h.first_sig, bus_h.first_dir});
        check_inst({tag, "/cont"}, 1, bus_c.state,
                   {bus_c.viol, bus_c.err_in, bus_c.err_out, bus_c.err_multi, bus_c.err_ena, bus_c.halted},
                   bus_c.viol_cnt, {bus_c.first_state, bus_c.first_sig, bus_c.first_dir});
    endtask

    task automatic step(input logic [NSIG-1:0] s, input logic [ENA_W-1:0] e, input logic c, input string tag);
        sig_d = s; ena_d = e; clr_d = c;
        @(posedge clk);
        model_edge();
        #1 check_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; sig_d = '0; ena_d = '0; clr_d = 1'b0;
        model_reset();
        #1 check_all("reset");
        @(negedge clk) rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // Legal handshake twice: 0->1->2->3->0
        for (int r = 0; r < 2; r++) begin
            step(2'b01, 4'b0000, 1'b0, "hs_a_rise");
            step(2'b11, 4'b0001, 1'b0, "hs_b_rise");
            step(2'b10, 4'b0000, 1'b0, "hs_a_fall");
            step(2'b00, 4'b1000, 1'b0, "hs_b_fall");
        end
        chk("hs_no_viol_cnt", 32'(bus_c.viol_cnt), 32'd0);

        // Async reset in state 2, between clock edges
        step(2'b01, 4'b0000, 1'b0, "pre_rst_a");
        step(2'b11, 4'b0000, 1'b0, "pre_rst_b");
        chk("pre_rst_state2", 32'(bus_h.state), 32'd2);
        #3 rst_n = 1'b0; sig_d = '0;
        model_reset();
        #1 check_all("async_rst");
        @(negedge clk) rst_n = 1'b1;

        // Illegal output edge from state 0, then edges while halted
        step(2'b10, 4'b0000, 1'b0, "b_rise_s0");
        chk("b_rise_first", {28'd0, bus_h.first_state, bus_h.first_sig, bus_h.first_dir}, 32'b0011);
        step(2'b10, 4'b0000, 1'b0, "viol_one_cycle");
        step(2'b11, 4'b0000, 1'b0, "halted_edge");
        step(2'b11, 4'b0000, 1'b1, "clear1");

        // Both signals toggle together
        step(2'b00, 4'b0000, 1'b0, "multi");
        step(2'b00, 4'b0000, 1'b1, "clear2");

        // ena not one-hot, then clear keeps state
        step(2'b00, 4'b0101, 1'b0, "ena_bad");
        step(2'b00, 4'b0000, 1'b1, "clear3");
        step(2'b00, 4'b0000, 1'b0, "after_clear");

        // Saturation: repeated illegal input edges from state 1
        do_reset();
        step(2'b01, 4'b0000, 1'b0, "sat_to_s1");
        for (int i = 0; i < 300; i++)
            step((i % 2 == 0) ? 2'b00 : 2'b01, 4'b0000, 1'b0, "sat");
        chk("sat_cnt", 32'(bus_c.viol_cnt), 32'd255);
        chk("sat_err_in", 32'(bus_c.err_in), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [NSIG-1:0]  s;
            logic [ENA_W-1:0] e;
            int r;
            s = sig_d;
            r = $urandom_range(0, 9);
            if (r < 7) s[$urandom_range(0, NSIG - 1)] ^= 1'b1;
            else if (r == 7) s = ~s;
            r = $urandom_range(0, 19);
            if (r == 0) e = ENA_W'($urandom);
            else if (r < 10) e = '0;
            else e = ENA_W'(1) << $urandom_range(0, ENA_W - 1);
            step(s, e, ($urandom_range(0, 15) == 0), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sg_monitor.md
# sg_monitor

Synthesizable, parametrised state-graph conformance monitor. It tracks a circuit's signals against a state graph supplied as parameter tables, classifies every illegal edge as an environment (input) or circuit (output) violation, and records diagnostics. It sits beside the circuit under test in emulation/FPGA runs, alongside the formal property module, and consumes the same signal set and one-hot `ena` constraint.

## Interface

**Parameters**
- `NSIG`, 4: number of monitored signals.
- `NSTATE`, 16: number of state-graph states.
- `NTRANS`, 32: number of transition-table entries.
- `ENA_W`, 4: width of the `ena` vector.
- `CNT_W`, 8: violation counter width.
- `SW`, `$clog2(NSTATE)`: state index width (derived).
- `XW`, `$clog2(NSIG)`: signal index width (derived).
- `INIT_STATE`, 0: state after reset.
- `INIT_SIG`, 0: expected signal values after reset (`NSIG` bits).
- `INPUT_MASK`, 0: bit i = 1 means signal i is an input (environment-driven).
- `TR_FROM`, `TR_SIG`, `TR_DIR`, `TR_TO`: packed `NTRANS`-entry tables giving source state, signal index, direction (1 = rise), and destination state.
- `HALT_ON_ERR`, 1: 1 freezes tracking after the first violation; 0 keeps checking from the current state.

**Ports**
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `ena`, in, `ENA_W`: enable vector; must be one-hot or zero.
- `sig`, in, `NSIG`: monitored signals.
- `clear`, in, 1: synchronous clear of the sticky flags, counter and capture registers.
- `state`, out, `SW`: current tracked state.
- `viol`, out, 1: single-cycle violation pulse.
- `err_in`, `err_out`, `err_multi`, `err_ena`, out, 1 each: sticky violation class flags.
- `viol_cnt`, out, `CNT_W`: saturating violation count.
- `first_state`, out, `SW`; `first_sig`, out, `XW`; `first_dir`, out, 1: capture of the first violation.
- `halted`, out, 1: tracking frozen.

## Operation
- `sig_q` holds the previously sampled signal values. Edge vector `e = sig ^ sig_q`. Edge direction for signal i is `sig[i]`.
- Evaluation each cycle, in priority order:
  1. `ena` not onehot0: `err_ena` violation. State is unchanged.
  2. popcount(e) > 1: `err_multi` violation. Capture the lowest edged index.
  3. popcount(e) == 1: search the table for an entry matching (`state`, index, direction).
     - Hit: `state <= TR_TO`. Lowest table index wins if several entries match.
     - Miss: violation, classed `err_in` if `INPUT_MASK[i]` is set, else `err_out`.
  4. popcount(e) == 0: no action.
- `sig_q <= sig` every cycle, whether or not a violation occurs, so one bad edge reports once.
- On a violation:
  - `viol` pulses.
  - The matching sticky flag sets.
  - `viol_cnt` increments, saturating at all-ones.
  - `first_*` load only if no violation has been captured since reset or `clear`.
- `HALT_ON_ERR` = 1: `halted` sets on the first violation. While halted, state stops updating and no further violations are flagged; `viol_cnt` stays fixed.
- `clear` zeroes flags, counter, captures and `halted`. It does not touch `state` or `sig_q`.
  - `clear` in the same cycle as a violation: the new violation wins and sets its flag, with count 1.
- Tracking continues even when `ena` is 0. `ena` is checked only for one-hotness.

## Timing
- Reset values:
  - `state = INIT_STATE`, `sig_q = INIT_SIG`.
  - All flags, `viol`, `halted` and `viol_cnt` = 0; `first_*` = 0.
- Latency: an edge on `sig` in cycle n updates `state`/flags/`viol` at the clk edge ending cycle n. Outputs are visible in cycle n+1. `viol` is registered and lasts exactly 1 cycle.
- Asynchronous reset during operation: all registers return immediately to their reset values, with no partial capture.
- Table search is combinational over `NTRANS` entries in a single cycle.

## Structure
- Package `sg_monitor_pkg`:
  - Violation-kind enum `{V_NONE, V_ENA, V_MULTI, V_IN, V_OUT}`.
  - Direction constants `DIR_FALL`/`DIR_RISE`.
  - Helper function `tr_entry` for packing table entries.
- One sub-module, `sg_tr_lookup`: combinational match of (state, index, dir) against the tables. It returns `hit` and `to`, with a priority encoder on the lowest entry.

## Test plan
- 2-signal handshake graph (`a` input, `b` output, 4 states). Drive the sequence a↑ b↑ a↓ b↓ twice -> state cycles 0→1→2→3→0; `viol` never asserts, `viol_cnt` = 0.
- From state 0, raise `b` -> `viol` pulses 1 cycle, `err_out` = 1, `first_state` = 0, `first_sig` = 1, `first_dir` = 1. With `HALT_ON_ERR` = 1, `halted` = 1 and `state` stays 0 for subsequent edges.
- With `HALT_ON_ERR` = 0, inject 300 illegal input edges -> `err_in` = 1, `viol_cnt` saturates at 255, first capture is unchanged.
- Toggle `a` and `b` in the same cycle -> `err_multi` = 1, `first_sig` = 0, state unchanged.
- Set `ena` = 4'b0101 -> `err_ena` = 1. Then pulse `clear` -> all flags, the counter and `halted` return to 0, while `state` is retained.
- Assert `reset` low mid-sequence in state 2 -> `state` = 0 asynchronously and all outputs take their reset values.
